// File: rtl/tutorial_switch_debounce.sv
// Input conditioning for the LED blinker: synchronizes and debounces two
// frequency-select switches and a push-button. Each debounced button press
// emits a one-cycle strobe and toggles the enable level.
module tutorial_switch_debounce #(
  parameter int unsigned c_DEBOUNCE_LIMIT = 250,
  parameter logic        c_ENABLE_RESET   = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_switch_1_raw,
  input  logic i_switch_2_raw,
  input  logic i_button_raw,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_enable,
  output logic o_button_pulse
);

  localparam int unsigned NumChan = 3;
  localparam int unsigned ChanBtn = 2;
  localparam logic [31:0] CntMax  = 32'(c_DEBOUNCE_LIMIT - 1);

  // Channel order: 0 = switch 1, 1 = switch 2, 2 = button.
  logic [NumChan-1:0] raw;
  logic [NumChan-1:0] sync1_q;
  logic [NumChan-1:0] sync2_q;
  logic [NumChan-1:0] stable_q;
  logic [NumChan-1:0] stable_d;
  logic [31:0]        cnt_q [NumChan];
  logic [31:0]        cnt_d [NumChan];

  logic btn_prev_q;
  logic btn_rise;
  logic pulse_q;
  logic enable_q;

  assign raw = {i_button_raw, i_switch_2_raw, i_switch_1_raw};

  // Two-flop synchronizer per raw input.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: accept a new level only after it has differed from
  // the stable level for c_DEBOUNCE_LIMIT consecutive cycles.
  always_comb begin
    stable_d = stable_q;
    for (int c = 0; c < NumChan; c++) begin
      cnt_d[c] = cnt_q[c];
      if (sync2_q[c] == stable_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CntMax) begin
        stable_d[c] = sync2_q[c];
        cnt_d[c]    = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + 32'd1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stable_q <= '0;
      for (int c = 0; c < NumChan; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int c = 0; c < NumChan; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Only the debounced press edge counts; release is ignored.
  assign btn_rise = stable_q[ChanBtn] & ~btn_prev_q;

  // Button edge detect, press strobe and enable toggle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      btn_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
      enable_q   <= c_ENABLE_RESET;
    end else begin
      btn_prev_q <= stable_q[ChanBtn];
      pulse_q    <= btn_rise;
      if (btn_rise) begin
        enable_q <= ~enable_q;
      end
    end
  end

  assign o_switch_1     = stable_q[0];
  assign o_switch_2     = stable_q[1];
  assign o_button_pulse = pulse_q;
  assign o_enable       = enable_q;

endmodule

// File: tb/tb_tutorial_switch_debounce.sv
// Bench for tutorial_switch_debounce: directed timing scenarios followed by
// randomized bouncing inputs, all checked against a sample-history model.
module tb_tutorial_switch_debounce;

  localparam int L = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] raw;  // 0 = sw1, 1 = sw2, 2 = button
  logic       o_sw1, o_sw2, o_en, o_pulse;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // Model: per-edge history of sampled raw levels (zeroed by reset), plus the
  // debounced levels and the button bookkeeping derived from it.
  logic [2:0] hist[$];
  logic [2:0] m_stable;
  logic       m_prev, m_pulse, m_en;

  tutorial_switch_debounce #(
    .c_DEBOUNCE_LIMIT(L),
    .c_ENABLE_RESET  (1'b1)
  ) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_switch_1_raw (raw[0]),
    .i_switch_2_raw (raw[1]),
    .i_button_raw   (raw[2]),
    .o_switch_1     (o_sw1),
    .o_switch_2     (o_sw2),
    .o_enable       (o_en),
    .o_button_pulse (o_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // One clock edge: record the sample, advance the model, compare outputs.
  task automatic step();
    logic [2:0] smp;
    logic       rs;
    logic [2:0] old_stable;
    logic       old_prev;
    logic       all_diff;
    int         n;
    smp = raw;
    rs  = rst_n;
    @(posedge clk);
    n = hist.size();
    if (!rs) begin
      hist.push_back(3'b000);
      // The sample taken one edge earlier is lost to the async clear too.
      if (n > 0) hist[n-1] = 3'b000;
      m_stable = '0;
      m_prev   = 1'b0;
      m_pulse  = 1'b0;
      m_en     = 1'b1;
    end else begin
      hist.push_back(smp);
      old_stable = m_stable;
      old_prev   = m_prev;
      // A level seen at the synchronizer output on edge k was sampled at edge
      // k-2; the output flips once L consecutive such levels disagree.
      if (n >= L + 1) begin
        for (int c = 0; c < 3; c++) begin
          all_diff = 1'b1;
          for (int j = 0; j < L; j++) begin
            if (hist[n-2-j][c] == old_stable[c]) all_diff = 1'b0;
          end
          if (all_diff) m_stable[c] = ~old_stable[c];
        end
      end
      m_pulse = old_stable[2] & ~old_prev;
      m_prev  = old_stable[2];
      if (m_pulse) m_en = ~m_en;
    end
    #1;
    chk("model_sw1", o_sw1, m_stable[0]);
    chk("model_sw2", o_sw2, m_stable[1]);
    chk("model_pulse", o_pulse, m_pulse);
    chk("model_en", o_en, m_en);
    if (o_pulse === 1'b1) pulses++;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  int p0;
  int run[3];
  int rst_hold;

  initial begin
    m_stable = '0;
    m_prev   = 1'b0;
    m_pulse  = 1'b0;
    m_en     = 1'b1;

    // Reset held with all raw inputs high.
    rst_n = 1'b0;
    raw   = 3'b111;
    steps(3);
    chk("rst_sw1", o_sw1, 1'b0);
    chk("rst_sw2", o_sw2, 1'b0);
    chk("rst_en", o_en, 1'b1);
    chk("rst_pulse", o_pulse, 1'b0);
    raw = 3'b000;
    step();
    rst_n = 1'b1;
    steps(8);

    // Clean switch 1 change: rises exactly at E0+5.
    raw[0] = 1'b1;
    steps(5);  // E0..E0+4
    chk("clean_sw1_early", o_sw1, 1'b0);
    step();    // E0+5
    chk("clean_sw1_rise", o_sw1, 1'b1);
    chk("clean_sw2_quiet", o_sw2, 1'b0);
    steps(3);

    // Async reset between edges clears outputs without a clock.
    rst_n = 1'b0;
    #1;
    chk("async_sw1", o_sw1, 1'b0);
    chk("async_pulse", o_pulse, 1'b0);
    chk("async_en", o_en, 1'b1);
    steps(2);
    rst_n = 1'b1;
    raw = 3'b000;
    steps(10);

    // Bounce on switch 2: runs 3 high, 1 low, 2 high, 3 low, then hold high.
    raw[1] = 1'b1; steps(3); chk("bounce_a", o_sw2, 1'b0);
    raw[1] = 1'b0; steps(1); chk("bounce_b", o_sw2, 1'b0);
    raw[1] = 1'b1; steps(2); chk("bounce_c", o_sw2, 1'b0);
    raw[1] = 1'b0; steps(3); chk("bounce_d", o_sw2, 1'b0);
    raw[1] = 1'b1;
    steps(5);
    chk("bounce_sw2_early", o_sw2, 1'b0);
    step();
    chk("bounce_sw2_rise", o_sw2, 1'b1);
    raw = 3'b000;
    steps(12);

    // Button press, release, press: two pulses, enable 1 -> 0 -> 1.
    p0 = pulses;
    raw[2] = 1'b1;
    steps(6);
    chk("btn1_pulse_early", o_pulse, 1'b0);
    chk("btn1_en_early", o_en, 1'b1);
    step();
    chk("btn1_pulse", o_pulse, 1'b1);
    chk("btn1_en", o_en, 1'b0);
    step();
    chk("btn1_pulse_width", o_pulse, 1'b0);
    steps(2);
    raw[2] = 1'b0;
    steps(10);
    chk("btn_release_nopulse", (pulses - p0 == 1), 1'b1);
    chk("btn_release_en", o_en, 1'b0);
    raw[2] = 1'b1;
    steps(7);
    chk("btn2_pulse", o_pulse, 1'b1);
    chk("btn2_en", o_en, 1'b1);
    steps(3);
    raw[2] = 1'b0;
    steps(10);
    chk("btn_two_pulses", (pulses - p0 == 2), 1'b1);

    // Reset mid-count with the button held high.
    p0 = pulses;
    raw[2] = 1'b1;
    steps(3);  // E0..E0+2
    rst_n = 1'b0;
    step();    // E0+3 in reset
    rst_n = 1'b1;
    chk("midrst_en_reset", o_en, 1'b1);
    chk("midrst_no_pulse", (pulses == p0), 1'b1);
    steps(6);
    chk("midrst_pulse_early", o_pulse, 1'b0);
    step();
    chk("midrst_pulse", o_pulse, 1'b1);
    chk("midrst_en", o_en, 1'b0);
    steps(5);
    raw[2] = 1'b0;
    steps(12);
    chk("midrst_one_pulse", (pulses - p0 == 1), 1'b1);

    // Simultaneous changes on all three inputs.
    p0 = pulses;
    raw = 3'b111;
    steps(5);
    chk("sim_sw1_early", o_sw1, 1'b0);
    step();
    chk("sim_sw1", o_sw1, 1'b1);
    chk("sim_sw2", o_sw2, 1'b1);
    chk("sim_pulse_early", o_pulse, 1'b0);
    step();
    chk("sim_pulse", o_pulse, 1'b1);
    chk("sim_en", o_en, 1'b1);
    steps(12);
    chk("sim_one_pulse", (pulses - p0 == 1), 1'b1);

    // Randomized bouncing with occasional resets.
    for (int c = 0; c < 3; c++) run[c] = $urandom_range(1, 9);
    rst_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (run[c] == 0) begin
          raw[c] = ~raw[c];
          run[c] = $urandom_range(1, 9);
        end
        run[c]--;
      end
      if (rst_hold > 0) begin
        rst_hold--;
        rst_n = (rst_hold == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        rst_n    = 1'b0;
        rst_hold = 2;
      end
      step();
    end
    rst_n = 1'b1;
    steps(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
